// File: rtl/nibble_serial_adder_pkg.sv
// Shared definitions for the nibble-serial adder: state encoding, slice width
// and the elaboration-time WIDTH legality check.
package nibble_serial_adder_pkg;

    localparam int NIBBLE_W = 4;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_DONE = 2'd2;

    function automatic bit width_legal(input int w);
        return (w % NIBBLE_W == 0) && (w >= 2 * NIBBLE_W);
    endfunction

endpackage

// File: rtl/nibble_serial_adder_if.sv
// Operand/result bundle between the requester and the nibble-serial adder.
interface nibble_serial_adder_if #(
    parameter int WIDTH = 16
);

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             overflow;

    modport master (
        output start, a, b, c_in,
        input  busy, done, sum, c_out, overflow
    );

    modport slave (
        input  start, a, b, c_in,
        output busy, done, sum, c_out, overflow
    );

endinterface

// File: rtl/nibble_serial_adder_rca.sv
// Purely combinational 4-bit ripple-carry slice shared across all nibbles.
module rca_4_bit
    import nibble_serial_adder_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                c_in,
    output logic [NIBBLE_W-1:0] s,
    output logic                c_out
);

    logic c1, c2, c3;

    assign s[0]  = a[0] ^ b[0] ^ c_in;
    assign c1    = (a[0] & b[0]) | (c_in & (a[0] ^ b[0]));
    assign s[1]  = a[1] ^ b[1] ^ c1;
    assign c2    = (a[1] & b[1]) | (c1 & (a[1] ^ b[1]));
    assign s[2]  = a[2] ^ b[2] ^ c2;
    assign c3    = (a[2] & b[2]) | (c2 & (a[2] ^ b[2]));
    assign s[3]  = a[3] ^ b[3] ^ c3;
    assign c_out = (a[3] & b[3]) | (c3 & (a[3] ^ b[3]));

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder: one 4-bit slice, LSB nibble first, carry
// registered between cycles, result published for one done cycle and held.
module nibble_serial_adder
    import nibble_serial_adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input logic                 clk,
    input logic                 rst_n,
    nibble_serial_adder_if.slave bus
);

    localparam int NIBBLES = WIDTH / NIBBLE_W;
    localparam int CNT_W   = $clog2(NIBBLES);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NIBBLES - 1);

    if (!width_legal(WIDTH)) begin : g_bad_width
        $error("nibble_serial_adder: WIDTH must be a multiple of 4 and >= 8");
    end

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic [WIDTH-1:0]    a_sh;
    logic [WIDTH-1:0]    b_sh;
    logic [WIDTH-1:0]    sum_sh;
    logic                carry;
    logic                a_msb;
    logic                b_msb;
    logic [WIDTH-1:0]    sum_q;
    logic                c_out_q;
    logic                ovf_q;

    logic [NIBBLE_W-1:0] s4;
    logic                slice_c;
    logic [WIDTH-1:0]    sum_next;

    rca_4_bit u_slice (
        .a     (a_sh[NIBBLE_W-1:0]),
        .b     (b_sh[NIBBLE_W-1:0]),
        .c_in  (carry),
        .s     (s4),
        .c_out (slice_c)
    );

    // New nibble enters at the top so the LSB nibble ends up at bit 0 after NIBBLES shifts.
    assign sum_next = {s4, sum_sh[WIDTH-1:NIBBLE_W]};

    // NOTE: every register, including the operand shift registers, is cleared by
    // the synchronous reset so a restarted op never sees stale nibbles; all state
    // uses non-blocking assignments so each branch reads pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            a_sh    <= '0;
            b_sh    <= '0;
            sum_sh  <= '0;
            carry   <= 1'b0;
            a_msb   <= 1'b0;
            b_msb   <= 1'b0;
            sum_q   <= '0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (bus.start) begin
                        state   <= ST_RUN;
                        a_sh    <= bus.a;
                        b_sh    <= bus.b;
                        carry   <= bus.c_in;
                        cnt     <= '0;
                        a_msb   <= bus.a[WIDTH-1];
                        b_msb   <= bus.b[WIDTH-1];
                        sum_sh  <= '0;
                        sum_q   <= '0;
                        c_out_q <= 1'b0;
                        ovf_q   <= 1'b0;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    sum_sh <= sum_next;
                    carry  <= slice_c;
                    a_sh   <= a_sh >> NIBBLE_W;
                    b_sh   <= b_sh >> NIBBLE_W;
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST_CNT) begin
                        state   <= ST_DONE;
                        sum_q   <= sum_next;
                        c_out_q <= slice_c;
                        ovf_q   <= (a_msb == b_msb) && (sum_next[WIDTH-1] != a_msb);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy     = (state == ST_RUN);
    assign bus.done     = (state == ST_DONE);
    assign bus.sum      = sum_q;
    assign bus.c_out    = c_out_q;
    assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench: directed vectors with literal expectations plus a
// cycle-accurate arithmetic reference compared on every falling edge.
module tb_nibble_serial_adder;

    localparam int WIDTH   = 16;
    localparam int NIBBLES = WIDTH / 4;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    nibble_serial_adder_if #(.WIDTH(WIDTH)) bus ();

    nibble_serial_adder #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: result is plain (a+b+c_in) mod 2^WIDTH, visible NIBBLES+1 cycles after acceptance.
    int               m_left;
    logic             m_done;
    logic [WIDTH-1:0] m_sum;
    logic             m_cout;
    logic             m_ovf;
    logic [WIDTH:0]   m_pend;
    logic             m_amsb;
    logic             m_bmsb;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_left <= 0;
            m_done <= 1'b0;
            m_sum  <= '0;
            m_cout <= 1'b0;
            m_ovf  <= 1'b0;
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_done <= 1'b1;
                m_sum  <= m_pend[WIDTH-1:0];
                m_cout <= m_pend[WIDTH];
                m_ovf  <= (m_amsb == m_bmsb) && (m_pend[WIDTH-1] != m_amsb);
            end
        end else begin
            m_done <= 1'b0;
            if (bus.start) begin
                m_left <= NIBBLES;
                m_sum  <= '0;
                m_cout <= 1'b0;
                m_ovf  <= 1'b0;
                m_pend <= {1'b0, bus.a} + {1'b0, bus.b} + {{WIDTH{1'b0}}, bus.c_in};
                m_amsb <= bus.a[WIDTH-1];
                m_bmsb <= bus.b[WIDTH-1];
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            check("busy",     {31'd0, bus.busy},     {31'd0, m_left > 0});
            check("done",     {31'd0, bus.done},     {31'd0, m_done});
            check("sum",      {16'd0, bus.sum},      {16'd0, m_sum});
            check("c_out",    {31'd0, bus.c_out},    {31'd0, m_cout});
            check("overflow", {31'd0, bus.overflow}, {31'd0, m_ovf});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One op from IDLE/DONE; optionally scrambles operands or re-pulses start during RUN.
    task automatic run_op(input string name, input logic [15:0] ta, input logic [15:0] tb_v,
                          input logic tc, input logic [15:0] es, input logic ec, input logic eo,
                          input bit scramble, input bit poke);
        int cycles;
        int busy_cnt;
        tick();
        bus.a = ta; bus.b = tb_v; bus.c_in = tc; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        cycles   = 1;
        busy_cnt = 0;
        while (!bus.done && cycles < 20) begin
            if (bus.busy) busy_cnt++;
            if (scramble) begin
                bus.a = ~ta; bus.b = ta ^ tb_v; bus.c_in = ~tc;
            end
            if (poke && cycles == 2) begin
                bus.a = 16'hAAAA; bus.b = 16'h5555; bus.start = 1'b1;
            end else begin
                bus.start = 1'b0;
            end
            tick();
            cycles++;
        end
        bus.start = 1'b0;
        check({name, "_latency"},  cycles, 5);
        check({name, "_busy_len"}, busy_cnt, 4);
        check({name, "_sum"},      {16'd0, bus.sum},      {16'd0, es});
        check({name, "_c_out"},    {31'd0, bus.c_out},    {31'd0, ec});
        check({name, "_overflow"}, {31'd0, bus.overflow}, {31'd0, eo});
        tick();
        check({name, "_done_pulse"}, {31'd0, bus.done}, 32'd0);
        check({name, "_sum_held"},   {16'd0, bus.sum},  {16'd0, es});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int dones;
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.c_in = 1'b0;
        repeat (3) tick();
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_done", {31'd0, bus.done}, 32'd0);
        check("rst_sum",  {16'd0, bus.sum},  32'd0);
        rst_n = 1'b1;
        tick();

        run_op("t1_ffff_plus_1", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
        run_op("t2_pos_ovf",     16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b0);
        run_op("t2_neg_ovf",     16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0);
        run_op("t3_scramble",    16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0, 1'b1, 1'b0);
        run_op("t4_ignored",     16'h0F0F, 16'h0101, 1'b0, 16'h1010, 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (6) begin
            tick();
            check("t4_no_second_op", {31'd0, bus.busy | bus.done}, 32'd0);
        end

        // Reset lands in RUN cycle 3.
        tick();
        bus.a = 16'h2222; bus.b = 16'h3333; bus.c_in = 1'b0; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        check("t5_busy", {31'd0, bus.busy}, 32'd0);
        check("t5_done", {31'd0, bus.done}, 32'd0);
        check("t5_sum",  {16'd0, bus.sum},  32'd0);
        rst_n = 1'b1;
        repeat (6) begin
            tick();
            check("t5_idle_after", {31'd0, bus.busy | bus.done}, 32'd0);
        end
        run_op("t5_fresh", 16'h00FF, 16'h0F01, 1'b1, 16'h1001, 1'b0, 1'b0, 1'b0, 1'b0);

        // Start held high: random operands every cycle, checked by the reference each cycle.
        dones = 0;
        bus.start = 1'b1;
        repeat (1000 * (NIBBLES + 1)) begin
            bus.a = 16'($urandom);
            bus.b = 16'($urandom);
            bus.c_in = 1'($urandom);
            tick();
            if (bus.done) dones++;
        end
        bus.start = 1'b0;
        repeat (10) tick();
        check("t6_done_count", dones, 1000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
